rf_access_sequencer: RTL

Front-end controller for the GB80 register file. It arbitrates between two requesters, the execute unit and the fetch unit, and sequences each granted operation onto the register file's single 8-bit write/read port and its 16-bit address-read port. It splits 16-bit pair writes into two byte writes, captures read data, and returns an ack, plus an error for illegal targets, to the requester.

---
 rtl/gb80_rf_pkg.sv | 34 +++
 rtl/rf_rr_arbiter.sv | 34 +++
 rtl/rf_access_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/gb80_rf_pkg.sv
// Shared encodings for the GB80 register-file access path: op codes, pair and
// register codes, and the sequencer state type.
package gb80_rf_pkg;

  typedef enum logic [1:0] {
    RF_OP_RD8  = 2'd0,
    RF_OP_WR8  = 2'd1,
    RF_OP_RD16 = 2'd2,
    RF_OP_WR16 = 2'd3
  } rf_op_e;

  localparam logic [2:0] RF_PAIR_BC = 3'd0;
  localparam logic [2:0] RF_PAIR_DE = 3'd1;
  localparam logic [2:0] RF_PAIR_HL = 3'd2;
  localparam logic [2:0] RF_PAIR_PC = 3'd3;

  localparam logic [2:0] RF_REG_B   = 3'd0;
  localparam logic [2:0] RF_REG_C   = 3'd1;
  localparam logic [2:0] RF_REG_D   = 3'd2;
  localparam logic [2:0] RF_REG_E   = 3'd3;
  localparam logic [2:0] RF_REG_H   = 3'd4;
  localparam logic [2:0] RF_REG_L   = 3'd5;
  localparam logic [2:0] RF_REG_MEM = 3'd6;
  localparam logic [2:0] RF_REG_A   = 3'd7;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StIssueLo,
    StCapture,
    StAck
  } rf_state_e;

endpackage

// File: rtl/rf_rr_arbiter.sv
// Two-way round-robin arbiter between execute and fetch. Grants only while
// enabled; the last-grant register starts on fetch so execute wins the first tie.
module rf_rr_arbiter (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic req_ex_i,
  input  logic req_fe_i,
  output logic gnt_ex_o,
  output logic gnt_fe_o
);

  logic last_fe_q, last_fe_d;

  always_comb begin
    gnt_ex_o  = en_i & req_ex_i & (~req_fe_i | last_fe_q);
    gnt_fe_o  = en_i & req_fe_i & (~req_ex_i | ~last_fe_q);
    last_fe_d = last_fe_q;
    if (gnt_ex_o) begin
      last_fe_d = 1'b0;
    end else if (gnt_fe_o) begin
      last_fe_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_fe_q <= 1'b1;
    end else begin
      last_fe_q <= last_fe_d;
    end
  end

endmodule

// File: rtl/rf_access_sequencer.sv
// Register-file front end: arbitrates execute/fetch requests and sequences each
// granted op onto the RF byte port and pair-read port, acking the requester.
module rf_access_sequencer
  import gb80_rf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDRESS_WIDTH = 3
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_ex_req,
  input  logic [1:0]                i_ex_op,
  input  logic [ADDRESS_WIDTH-1:0]  i_ex_addr,
  input  logic [2*DATA_WIDTH-1:0]   i_ex_wdata,
  output logic                      o_ex_ack,
  output logic                      o_ex_err,
  input  logic                      i_fe_req,
  input  logic [1:0]                i_fe_op,
  input  logic [ADDRESS_WIDTH-1:0]  i_fe_addr,
  input  logic [2*DATA_WIDTH-1:0]   i_fe_wdata,
  output logic                      o_fe_ack,
  output logic                      o_fe_err,
  output logic [2*DATA_WIDTH-1:0]   o_rdata,
  output logic                      o_rf_wr_en,
  output logic                      o_rf_rd_en,
  output logic                      o_rf_rd_addr_en,
  output logic [ADDRESS_WIDTH-1:0]  o_rf_addr,
  output logic [DATA_WIDTH-1:0]     o_rf_data,
  input  logic [DATA_WIDTH-1:0]     i_rf_data,
  input  logic [2*DATA_WIDTH-1:0]   i_rf_addr_data
);

  function automatic logic is_illegal(rf_op_e op, logic [ADDRESS_WIDTH-1:0] a);
    case (op)
      RF_OP_WR8:  return a == ADDRESS_WIDTH'(RF_REG_MEM);
      RF_OP_RD16: return a > ADDRESS_WIDTH'(RF_PAIR_PC);
      RF_OP_WR16: return a >= ADDRESS_WIDTH'(RF_PAIR_PC);
      default:    return 1'b0;
    endcase
  endfunction

  // Pair p maps to byte registers 2p (high) and 2p+1 (low).
  function automatic logic [ADDRESS_WIDTH-1:0] pair_reg(logic [ADDRESS_WIDTH-1:0] a, logic lo);
    return {a[ADDRESS_WIDTH-2:0], lo};
  endfunction

  rf_state_e                 state_q, state_d;
  logic                      id_fe_q, id_fe_d;
  rf_op_e                    op_q, op_d;
  logic [ADDRESS_WIDTH-1:0]  lo_addr_q, lo_addr_d;
  logic [DATA_WIDTH-1:0]     wlo_q, wlo_d;
  logic                      err_q, err_d;
  logic [2*DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                      wr_en_q, wr_en_d;
  logic                      rd_en_q, rd_en_d;
  logic                      rd_addr_en_q, rd_addr_en_d;
  logic [ADDRESS_WIDTH-1:0]  rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0]     rf_data_q, rf_data_d;
  logic                      ex_ack_q, ex_ack_d, fe_ack_q, fe_ack_d;
  logic                      ex_err_q, ex_err_d, fe_err_q, fe_err_d;

  logic                      gnt_ex, gnt_fe;
  rf_op_e                    sel_op;
  logic [ADDRESS_WIDTH-1:0]  sel_addr;
  logic [2*DATA_WIDTH-1:0]   sel_wdata;

  rf_rr_arbiter u_arb (
    .clk_i    (i_clk),
    .rst_ni   (i_reset_n),
    .en_i     (state_q == StIdle),
    .req_ex_i (i_ex_req),
    .req_fe_i (i_fe_req),
    .gnt_ex_o (gnt_ex),
    .gnt_fe_o (gnt_fe)
  );

  assign sel_op    = gnt_fe ? rf_op_e'(i_fe_op) : rf_op_e'(i_ex_op);
  assign sel_addr  = gnt_fe ? i_fe_addr : i_ex_addr;
  assign sel_wdata = gnt_fe ? i_fe_wdata : i_ex_wdata;

  // Outputs are computed for the state being entered, so they are registered
  // yet still a pure function of (state, latched op).
  always_comb begin
    state_d      = state_q;
    id_fe_d      = id_fe_q;
    op_d         = op_q;
    lo_addr_d    = lo_addr_q;
    wlo_d        = wlo_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    rf_addr_d    = rf_addr_q;
    rf_data_d    = rf_data_q;
    wr_en_d      = 1'b0;
    rd_en_d      = 1'b0;
    rd_addr_en_d = 1'b0;
    ex_ack_d     = 1'b0;
    fe_ack_d     = 1'b0;
    ex_err_d     = 1'b0;
    fe_err_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (gnt_ex || gnt_fe) begin
          id_fe_d   = gnt_fe;
          op_d      = sel_op;
          lo_addr_d = pair_reg(sel_addr, 1'b1);
          wlo_d     = sel_wdata[DATA_WIDTH-1:0];
          err_d     = is_illegal(sel_op, sel_addr);
          if (err_d) begin
            state_d = StAck;
          end else begin
            state_d   = StIssue;
            rf_addr_d = sel_addr;
            case (sel_op)
              RF_OP_RD8:  rd_en_d = 1'b1;
              RF_OP_WR8: begin
                wr_en_d   = 1'b1;
                rf_data_d = sel_wdata[DATA_WIDTH-1:0];
              end
              RF_OP_RD16: rd_addr_en_d = 1'b1;
              default: begin
                wr_en_d   = 1'b1;
                rf_addr_d = pair_reg(sel_addr, 1'b0);
                rf_data_d = sel_wdata[2*DATA_WIDTH-1:DATA_WIDTH];
              end
            endcase
          end
        end
      end
      StIssue: begin
        case (op_q)
          RF_OP_WR16: begin
            state_d   = StIssueLo;
            wr_en_d   = 1'b1;
            rf_addr_d = lo_addr_q;
            rf_data_d = wlo_q;
          end
          RF_OP_RD8, RF_OP_RD16: state_d = StCapture;
          default:               state_d = StAck;
        endcase
      end
      StIssueLo: state_d = StAck;
      StCapture: begin
        rdata_d = (op_q == RF_OP_RD16) ? i_rf_addr_data
                                       : {{DATA_WIDTH{1'b0}}, i_rf_data};
        state_d = StAck;
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (state_d == StAck) begin
      ex_ack_d = ~id_fe_d;
      fe_ack_d = id_fe_d;
      ex_err_d = ~id_fe_d & err_d;
      fe_err_d = id_fe_d & err_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= StIdle;
      id_fe_q      <= 1'b0;
      op_q         <= RF_OP_RD8;
      lo_addr_q    <= '0;
      wlo_q        <= '0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_en_q <= 1'b0;
      rf_addr_q    <= '0;
      rf_data_q    <= '0;
      ex_ack_q     <= 1'b0;
      fe_ack_q     <= 1'b0;
      ex_err_q     <= 1'b0;
      fe_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      id_fe_q      <= id_fe_d;
      op_q         <= op_d;
      lo_addr_q    <= lo_addr_d;
      wlo_q        <= wlo_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      rd_addr_en_q <= rd_addr_en_d;
      rf_addr_q    <= rf_addr_d;
      rf_data_q    <= rf_data_d;
      ex_ack_q     <= ex_ack_d;
      fe_ack_q     <= fe_ack_d;
      ex_err_q     <= ex_err_d;
      fe_err_q     <= fe_err_d;
    end
  end

  assign o_ex_ack        = ex_ack_q;
  assign o_fe_ack        = fe_ack_q;
  assign o_ex_err        = ex_err_q;
  assign o_fe_err        = fe_err_q;
  assign o_rdata         = rdata_q;
  assign o_rf_wr_en      = wr_en_q;
  assign o_rf_rd_en      = rd_en_q;
  assign o_rf_rd_addr_en = rd_addr_en_q;
  assign o_rf_addr       = rf_addr_q;
  assign o_rf_data       = rf_data_q;

endmodule
